conv_layer_sequencer: RTL and testbench

Controller that runs one full 3x3 convolution pass of a single feature map through `convolutor3x3`. It sits between an input feature-map memory (1-cycle read latency) and an output buffer. It fetches pixels in raster order and drives the convolver's pixel stream, padding flags, operation, ReLU and reset. It aligns the convolver's pipelined result stream back to output pixel indices and writes them out, with a start/busy/done handshake to the layer scheduler above it.

---
 rtl/conv_seq_pkg.sv | 25 ++
 rtl/conv_seq_raster_cnt.sv | 47 ++++
 rtl/conv_layer_sequencer.sv | 164 ++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_seq_pkg: shared types and constants for the 3x3 layer sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package conv_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  // Operation codes understood by convolutor3x3
  localparam logic [1:0] CONV     = 2'd0;
  localparam logic [1:0] MAX_POOL = 2'd1;
  localparam logic [1:0] AVG_POOL = 2'd2;
  localparam logic [1:0] MIN_POOL = 2'd3;

  localparam int DEF_MAX_WIDTH  = 128;
  localparam int DEF_MAX_HEIGHT = 128;

endpackage
`default_nettype wire

// File: rtl/conv_seq_raster_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_seq_raster_cnt: column/row tracker for the convolver feed slot  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module conv_seq_raster_cnt #(
  parameter int ROW_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       adv_i,
  input  logic [7:0] width_i,
  input  logic [7:0] height_i,
  output logic [7:0] col_o,
  output logic       last_slot_o,
  output logic       trail_o
);

  logic [7:0]       col_q;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] h_row;
  logic             last_col;

  assign h_row       = ROW_W'(height_i);
  assign last_col    = (col_q == width_i - 8'd1);
  assign col_o       = col_q;
  // Rows at or beyond H are the trailing zero-padding rows
  assign trail_o     = (row_q >= h_row);
  assign last_slot_o = (row_q == h_row + ROW_W'(1)) && (col_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (adv_i) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_layer_sequencer: runs one 3x3 convolution pass over a feature   |
// | map, feeding convolutor3x3 and writing aligned results.  Rev 1.0     |
// +----------------------------------------------------------------------+
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
  parameter int MAX_HEIGHT = DEF_MAX_HEIGHT,
  parameter int ADDR_W     = 14,
  parameter int DW_IN      = 8,
  parameter int DW_OUT     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        width,
  input  logic [7:0]        height,
  input  logic [1:0]        op,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [DW_IN-1:0]  in_data,
  output logic [DW_IN-1:0]  cv_pixel_in,
  output logic              cv_paddingl,
  output logic              cv_paddingr,
  output logic [1:0]        cv_operation,
  output logic              cv_relu,
  output logic [7:0]        cv_width,
  output logic              cv_rst_n,
  input  logic [DW_OUT-1:0] cv_pixel_out,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DW_OUT-1:0] out_data
);

  localparam int CNT_W = $clog2(MAX_WIDTH * MAX_HEIGHT + MAX_WIDTH + 2);
  localparam int ROW_W = $clog2(MAX_HEIGHT + 2);
  localparam logic [CNT_W-1:0] MAX_W_C = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] MAX_H_C = CNT_W'(MAX_HEIGHT);

  seq_state_e state_q, state_d;

  logic [7:0]        width_q, height_q;
  logic [1:0]        op_q;
  logic              relu_q;
  logic [CNT_W-1:0]  n_q, f_end_q, lag_q, f_q, p_q;
  logic              feed_vld_q, slot_vld_q;
  logic              cfg_err_q, wr_q, last_wr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DW_OUT-1:0] out_data_q;

  logic       accept, cfg_ok, go, slot_out;
  logic [7:0] col;
  logic       last_slot, trail;

  assign accept   = (state_q == S_IDLE) && start;
  assign cfg_ok   = (width >= 8'd2) && (height != 8'd0) &&
                    (CNT_W'(width) <= MAX_W_C) && (CNT_W'(height) <= MAX_H_C);
  assign go       = accept && cfg_ok;
  // Slots before W+1 only prime the convolver line buffers
  assign slot_out = slot_vld_q && (p_q >= lag_q);

  conv_seq_raster_cnt #(
    .ROW_W (ROW_W)
  ) u_raster (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (go),
    .adv_i       (slot_vld_q),
    .width_i     (width_q),
    .height_i    (height_q),
    .col_o       (col),
    .last_slot_o (last_slot),
    .trail_o     (trail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = cfg_ok ? S_FEED : S_DONE;
      S_FEED:  if (last_wr_q) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q    <= '0;
      height_q   <= '0;
      op_q       <= '0;
      relu_q     <= 1'b0;
      n_q        <= '0;
      f_end_q    <= '0;
      lag_q      <= '0;
      f_q        <= '0;
      p_q        <= '0;
      feed_vld_q <= 1'b0;
      slot_vld_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      wr_q       <= 1'b0;
      last_wr_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      cfg_err_q <= accept && !cfg_ok;
      if (go) begin
        width_q    <= width;
        height_q   <= height;
        op_q       <= op;
        relu_q     <= relu_en;
        n_q        <= CNT_W'(width) * CNT_W'(height);
        f_end_q    <= CNT_W'(width) * CNT_W'(height) + CNT_W'(width);
        lag_q      <= CNT_W'(width) + CNT_W'(1);
        f_q        <= '0;
        feed_vld_q <= 1'b1;
      end else if (feed_vld_q) begin
        f_q <= f_q + CNT_W'(1);
        if (f_q == f_end_q) feed_vld_q <= 1'b0;
      end
      // Slot stage trails the fetch by the memory read latency
      slot_vld_q <= feed_vld_q;
      p_q        <= f_q;
      wr_q       <= slot_out;
      last_wr_q  <= slot_vld_q && last_slot;
      if (slot_out) begin
        out_addr_q <= ADDR_W'(p_q - lag_q);
        out_data_q <= cv_pixel_out;
      end
    end
  end

  assign busy         = (state_q == S_FEED) || (state_q == S_FLUSH);
  assign done         = (state_q == S_DONE);
  assign cfg_err      = cfg_err_q;
  assign in_rd_en     = feed_vld_q && (f_q < n_q);
  assign in_addr      = in_rd_en ? ADDR_W'(f_q) : '0;
  assign cv_pixel_in  = (slot_vld_q && !trail) ? in_data : '0;
  assign cv_paddingl  = slot_vld_q && (col == 8'd0);
  assign cv_paddingr  = slot_vld_q && (col == 8'd1);
  assign cv_operation = op_q;
  assign cv_relu      = relu_q;
  assign cv_width     = width_q;
  assign cv_rst_n     = !(rst || (state_q == S_FLUSH));
  assign out_wr_en    = wr_q;
  assign out_addr     = out_addr_q;
  assign out_data     = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv_layer_sequencer: directed bench with memory and identity-    |
// | kernel convolver models.  Rev 1.0                                    |
// +----------------------------------------------------------------------+
module tb_conv_layer_sequencer;
  import conv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  width = '0, height = '0;
  logic [1:0]  op = '0;
  logic        relu_en = 1'b0;
  logic        busy, done, cfg_err, in_rd_en;
  logic [13:0] in_addr;
  logic [7:0]  in_data = '0;
  logic [7:0]  cv_pixel_in;
  logic        cv_paddingl, cv_paddingr;
  logic [1:0]  cv_operation;
  logic        cv_relu;
  logic [7:0]  cv_width;
  logic        cv_rst_n;
  logic [31:0] cv_pixel_out;
  logic        out_wr_en;
  logic [13:0] out_addr;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  conv_layer_sequencer #(
    .MAX_WIDTH (128), .MAX_HEIGHT (128), .ADDR_W (14), .DW_IN (8), .DW_OUT (32)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .width (width), .height (height),
    .op (op), .relu_en (relu_en), .busy (busy), .done (done), .cfg_err (cfg_err),
    .in_rd_en (in_rd_en), .in_addr (in_addr), .in_data (in_data),
    .cv_pixel_in (cv_pixel_in), .cv_paddingl (cv_paddingl), .cv_paddingr (cv_paddingr),
    .cv_operation (cv_operation), .cv_relu (cv_relu), .cv_width (cv_width),
    .cv_rst_n (cv_rst_n), .cv_pixel_out (cv_pixel_out), .out_wr_en (out_wr_en),
    .out_addr (out_addr), .out_data (out_data)
  );

  // Input memory with one cycle of read latency
  logic signed [7:0] mem [0:63];
  always @(posedge clk) if (in_rd_en) in_data <= mem[in_addr[5:0]];

  // Identity-kernel convolver: centre tap emerges W+1 slots after it was fed
  logic signed [7:0] dl [0:255];
  logic signed [7:0] ctr;
  always @(posedge clk) begin
    if (!cv_rst_n) begin
      for (int i = 0; i < 256; i++) dl[i] <= '0;
    end else begin
      dl[0] <= cv_pixel_in;
      for (int i = 1; i < 256; i++) dl[i] <= dl[i-1];
    end
  end
  always_comb begin
    ctr = dl[cv_width];
    cv_pixel_out = (cv_relu && ctr < 0) ? 32'd0 : {{24{ctr[7]}}, ctr};
  end

  // Cycle-indexed observation log, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic        l_busy [0:4095], l_rd [0:4095], l_pl [0:4095], l_pr [0:4095], l_flush [0:4095];
  logic [13:0] l_ia  [0:4095];
  logic [7:0]  l_pix [0:4095];
  logic [13:0] wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          wr_cyc  [0:1023];
  int wr_n = 0, done_n = 0, done_cyc = 0, cfg_n = 0, cfg_cyc = 0, rd_n = 0;
  always @(negedge clk) begin
    l_busy[cyc % 4096]  = busy;
    l_rd[cyc % 4096]    = in_rd_en;
    l_ia[cyc % 4096]    = in_addr;
    l_pl[cyc % 4096]    = cv_paddingl;
    l_pr[cyc % 4096]    = cv_paddingr;
    l_pix[cyc % 4096]   = cv_pixel_in;
    l_flush[cyc % 4096] = !cv_rst_n;
    if (in_rd_en) rd_n++;
    if (done) begin done_n++; done_cyc = cyc; end
    if (cfg_err) begin cfg_n++; cfg_cyc = cyc; end
    if (out_wr_en && wr_n < 1024) begin
      wr_addr[wr_n] = out_addr;
      wr_data[wr_n] = out_data;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
  end

  int n_cmp = 0, n_err = 0;
  int base = 0;

  function automatic logic [31:0] expv(input int k, input logic r);
    logic signed [7:0] v;
    v = mem[k];
    if (r && v < 0) return 32'd0;
    return {{24{v[7]}}, v};
  endfunction

  task automatic load_ramp(input int a, input int s);
    for (int i = 0; i < 64; i++) mem[i] = 8'(a + s * i);
  endtask

  // Pulses start for one cycle; on return the bench sits in cycle 1 of the pass
  task automatic do_start(input logic [7:0] w, input logic [7:0] h, input logic [1:0] o, input logic r);
    @(posedge clk); #1;
    start = 1'b1; width = w; height = h; op = o; relu_en = r;
    @(posedge clk); #1;
    start = 1'b0; width = 8'hAA; height = 8'h55; op = 2'd3; relu_en = ~r;
    base = cyc - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cv_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_cv_rst_n: got %b want 0", cv_rst_n); end
    n_cmp++;
    if ({busy, done, cfg_err, in_rd_en, out_wr_en, cv_paddingl, cv_paddingr, cv_relu} !== 8'd0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000000",
        {busy, done, cfg_err, in_rd_en, out_wr_en, cv_paddingl, cv_paddingr, cv_relu});
    end
    n_cmp++;
    if (in_addr !== 14'd0 || out_addr !== 14'd0 || out_data !== 32'd0) begin
      n_err++; $display("FAIL reset_addr_data: got %0h/%0h/%0h want 0/0/0", in_addr, out_addr, out_data);
    end
    n_cmp++;
    if (cv_pixel_in !== 8'd0 || cv_width !== 8'd0 || cv_operation !== 2'd0) begin
      n_err++; $display("FAIL reset_cv: got %0h/%0h/%0h want 0/0/0", cv_pixel_in, cv_width, cv_operation);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (cv_rst_n !== 1'b1) begin n_err++; $display("FAIL release_cv_rst_n: got %b want 1", cv_rst_n); end
  endtask

  task automatic test_identity();
    logic signed [7:0] img [16] = '{14, 1, 0, 100, 0, -1, 0, -100, 5, -6, 7, -8, 9, 10, -11, 12};
    int w0, d0, r0, nw, cnt;
    for (int i = 0; i < 64; i++) mem[i] = (i < 16) ? img[i] : 8'sd0;
    w0 = wr_n; d0 = done_n; r0 = rd_n;
    do_start(8'd4, 8'd4, MAX_POOL, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    nw = wr_n - w0;
    n_cmp++; if (nw !== 16) begin n_err++; $display("FAIL id_wr_count: got %0d want 16", nw); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (wr_addr[w0+i] !== 14'(i) || wr_data[w0+i] !== expv(i, 1'b1)) begin
        n_err++; $display("FAIL id_wr[%0d]: got addr %0d data %0h want addr %0d data %0h",
          i, wr_addr[w0+i], wr_data[w0+i], i, expv(i, 1'b1));
      end
    end
    n_cmp++; if (wr_cyc[w0] - base !== 8) begin n_err++; $display("FAIL id_first_wr_cycle: got %0d want 8", wr_cyc[w0] - base); end
    n_cmp++; if (wr_cyc[w0+15] - base !== 23) begin n_err++; $display("FAIL id_last_wr_cycle: got %0d want 23", wr_cyc[w0+15] - base); end
    n_cmp++; if (done_n - d0 !== 1) begin n_err++; $display("FAIL id_done_count: got %0d want 1", done_n - d0); end
    n_cmp++; if (done_cyc - base !== 25) begin n_err++; $display("FAIL id_done_cycle: got %0d want 25", done_cyc - base); end
    n_cmp++;
    if ({l_busy[base % 4096], l_busy[(base+1) % 4096], l_busy[(base+24) % 4096], l_busy[(base+25) % 4096], busy} !== 5'b01100) begin
      n_err++; $display("FAIL id_busy_c0_c1_c24_c25_now: got %b want 01100",
        {l_busy[base % 4096], l_busy[(base+1) % 4096], l_busy[(base+24) % 4096], l_busy[(base+25) % 4096], busy});
    end
    n_cmp++;
    if (l_rd[(base+1) % 4096] !== 1'b1 || l_ia[(base+1) % 4096] !== 14'd0 || l_ia[(base+16) % 4096] !== 14'd15 || l_rd[(base+17) % 4096] !== 1'b0) begin
      n_err++; $display("FAIL id_in_addr: got rd1=%b a1=%0d a16=%0d rd17=%b want 1/0/15/0",
        l_rd[(base+1) % 4096], l_ia[(base+1) % 4096], l_ia[(base+16) % 4096], l_rd[(base+17) % 4096]);
    end
    n_cmp++; if (rd_n - r0 !== 16) begin n_err++; $display("FAIL id_rd_count: got %0d want 16", rd_n - r0); end
    cnt = 0;
    for (int r = 1; r <= 28; r++) if (l_flush[(base+r) % 4096]) cnt++;
    n_cmp++;
    if (cnt !== 1 || l_flush[(base+24) % 4096] !== 1'b1) begin
      n_err++; $display("FAIL id_flush: got %0d low cycles, c24=%b want 1 at cycle 24", cnt, l_flush[(base+24) % 4096]);
    end
    n_cmp++;
    if (cv_operation !== MAX_POOL || cv_relu !== 1'b1 || cv_width !== 8'd4) begin
      n_err++; $display("FAIL id_latched_cfg: got op=%0d relu=%b w=%0d want 1/1/4", cv_operation, cv_relu, cv_width);
    end
  endtask

  task automatic test_padding();
    int w0, nw;
    logic [7:0] ep;
    load_ramp(-60, 9);
    w0 = wr_n;
    do_start(8'd5, 8'd3, CONV, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    for (int p = 0; p <= 20; p++) begin
      ep = (p < 15) ? mem[p] : 8'd0;
      n_cmp++;
      if (l_pl[(base+p+2) % 4096] !== (p % 5 == 0) || l_pr[(base+p+2) % 4096] !== (p % 5 == 1) || l_pix[(base+p+2) % 4096] !== ep) begin
        n_err++; $display("FAIL pad_slot[%0d]: got l=%b r=%b pix=%0h want l=%b r=%b pix=%0h", p,
          l_pl[(base+p+2) % 4096], l_pr[(base+p+2) % 4096], l_pix[(base+p+2) % 4096], p % 5 == 0, p % 5 == 1, ep);
      end
    end
    n_cmp++;
    if (l_pl[(base+25) % 4096] !== 1'b0 || l_pr[(base+25) % 4096] !== 1'b0 || l_pix[(base+25) % 4096] !== 8'd0) begin
      n_err++; $display("FAIL pad_outside_feed: got l=%b r=%b pix=%0h want 0/0/0",
        l_pl[(base+25) % 4096], l_pr[(base+25) % 4096], l_pix[(base+25) % 4096]);
    end
    nw = wr_n - w0;
    n_cmp++; if (nw !== 15) begin n_err++; $display("FAIL pad_wr_count: got %0d want 15", nw); end
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if (wr_addr[w0+i] !== 14'(i) || wr_data[w0+i] !== expv(i, 1'b0)) begin
        n_err++; $display("FAIL pad_wr[%0d]: got addr %0d data %0h want addr %0d data %0h",
          i, wr_addr[w0+i], wr_data[w0+i], i, expv(i, 1'b0));
      end
    end
    n_cmp++; if (done_cyc - base !== 25) begin n_err++; $display("FAIL pad_done_cycle: got %0d want 25", done_cyc - base); end
  endtask

  task automatic test_reject();
    logic [7:0] rw [3] = '{8'd1, 8'd4, 8'd200};
    logic [7:0] rh [3] = '{8'd4, 8'd0, 8'd4};
    int w0, d0, c0, r0, nb;
    for (int t = 0; t < 3; t++) begin
      w0 = wr_n; d0 = done_n; c0 = cfg_n; r0 = rd_n;
      do_start(rw[t], rh[t], CONV, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      nb = 0;
      for (int r = 0; r <= 5; r++) if (l_busy[(base+r) % 4096]) nb++;
      n_cmp++;
      if (done_n - d0 !== 1 || done_cyc - base !== 1 || cfg_n - c0 !== 1 || cfg_cyc - base !== 1) begin
        n_err++; $display("FAIL rej%0d_done_cfg: got done %0d@%0d cfg %0d@%0d want 1@1 1@1", t,
          done_n - d0, done_cyc - base, cfg_n - c0, cfg_cyc - base);
      end
      n_cmp++;
      if (nb !== 0 || rd_n - r0 !== 0 || wr_n - w0 !== 0) begin
        n_err++; $display("FAIL rej%0d_activity: got busy=%0d rd=%0d wr=%0d want 0/0/0", t, nb, rd_n - r0, wr_n - w0);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int w0, d0, nw;
    load_ramp(3, -4);
    w0 = wr_n; d0 = done_n;
    do_start(8'd4, 8'd4, AVG_POOL, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; width = 8'd3; height = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    nw = wr_n - w0;
    n_cmp++; if (nw !== 16) begin n_err++; $display("FAIL swb_wr_count: got %0d want 16", nw); end
    n_cmp++;
    if (done_n - d0 !== 1 || done_cyc - base !== 25) begin
      n_err++; $display("FAIL swb_done: got %0d@%0d want 1@25", done_n - d0, done_cyc - base);
    end
    n_cmp++; if (cv_width !== 8'd4) begin n_err++; $display("FAIL swb_width: got %0d want 4", cv_width); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (wr_addr[w0+i] !== 14'(i) || wr_data[w0+i] !== expv(i, 1'b1)) begin
        n_err++; $display("FAIL swb_wr[%0d]: got addr %0d data %0h want addr %0d data %0h",
          i, wr_addr[w0+i], wr_data[w0+i], i, expv(i, 1'b1));
      end
    end
  endtask

  task automatic test_reset_midpass();
    int w0, d0;
    load_ramp(-30, 7);
    do_start(8'd4, 8'd4, CONV, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (cv_rst_n !== 1'b0) begin n_err++; $display("FAIL mid_cv_rst_n: got %b want 0", cv_rst_n); end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, in_rd_en, out_wr_en, cv_paddingl, cv_paddingr} !== 6'd0 || cv_width !== 8'd0 ||
        in_addr !== 14'd0 || out_addr !== 14'd0 || out_data !== 32'd0 || cv_pixel_in !== 8'd0) begin
      n_err++; $display("FAIL mid_reset_values: got flags=%b w=%0d ia=%0d oa=%0d od=%0h pix=%0h want all 0",
        {busy, done, in_rd_en, out_wr_en, cv_paddingl, cv_paddingr}, cv_width, in_addr, out_addr, out_data, cv_pixel_in);
    end
    rst = 1'b0;
    w0 = wr_n; d0 = done_n;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_n - w0 !== 0 || done_n - d0 !== 0) begin
      n_err++; $display("FAIL mid_abandon: got wr=%0d done=%0d want 0/0", wr_n - w0, done_n - d0);
    end
    load_ramp(50, -6);
    w0 = wr_n; d0 = done_n;
    do_start(8'd4, 8'd4, CONV, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_n - w0 !== 16 || done_n - d0 !== 1 || done_cyc - base !== 25) begin
      n_err++; $display("FAIL mid_rerun: got wr=%0d done=%0d@%0d want 16 1@25", wr_n - w0, done_n - d0, done_cyc - base);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (wr_addr[w0+i] !== 14'(i) || wr_data[w0+i] !== expv(i, 1'b1)) begin
        n_err++; $display("FAIL mid_wr[%0d]: got addr %0d data %0h want addr %0d data %0h",
          i, wr_addr[w0+i], wr_data[w0+i], i, expv(i, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int w0, d0, cnt;
    load_ramp(-20, 3);
    w0 = wr_n;
    do_start(8'd4, 8'd4, CONV, 1'b1);
    repeat (24) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_c25: got %b want 1", done); end
    n_cmp++; if (wr_n - w0 !== 16) begin n_err++; $display("FAIL b2b_p1_count: got %0d want 16", wr_n - w0); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (wr_addr[w0+i] !== 14'(i) || wr_data[w0+i] !== expv(i, 1'b1)) begin
        n_err++; $display("FAIL b2b_p1_wr[%0d]: got addr %0d data %0h want addr %0d data %0h",
          i, wr_addr[w0+i], wr_data[w0+i], i, expv(i, 1'b1));
      end
    end
    load_ramp(40, -5);
    start = 1'b1; width = 8'd4; height = 8'd4; op = CONV; relu_en = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_start_in_done: got busy %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc - 1;
    w0 = wr_n; d0 = done_n;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got busy %b want 1", busy); end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_n - w0 !== 16 || done_n - d0 !== 1 || done_cyc - base !== 25) begin
      n_err++; $display("FAIL b2b_p2: got wr=%0d done=%0d@%0d want 16 1@25", wr_n - w0, done_n - d0, done_cyc - base);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (wr_addr[w0+i] !== 14'(i) || wr_data[w0+i] !== expv(i, 1'b0)) begin
        n_err++; $display("FAIL b2b_p2_wr[%0d]: got addr %0d data %0h want addr %0d data %0h",
          i, wr_addr[w0+i], wr_data[w0+i], i, expv(i, 1'b0));
      end
    end
    cnt = 0;
    for (int r = 1; r <= 28; r++) if (l_flush[(base+r) % 4096]) cnt++;
    n_cmp++;
    if (cnt !== 1 || l_flush[(base+24) % 4096] !== 1'b1) begin
      n_err++; $display("FAIL b2b_flush: got %0d low cycles, c24=%b want 1 at cycle 24", cnt, l_flush[(base+24) % 4096]);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_padding();
    test_reject();
    test_start_while_busy();
    test_reset_midpass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
